// File: rtl/apbdma_pkg.sv
// Shared APB-DMA datapath types.
// Holds FSM state encodings used by the DMA stream adapters.
package apbdma_pkg;

  typedef enum logic {
    Fill = 1'b0,
    Full = 1'b1
  } upsizer_state_e;

endpackage

// File: rtl/apbdma_upsizer_if.sv
// Narrow-in / wide-out stream bundle for the APB-DMA upsizer.
// flush_i exists only when APBDMA_UPSIZER_FLUSH_EN is defined.
interface apbdma_upsizer_if #(
  parameter int unsigned InDataWidth  = 32,
  parameter int unsigned OutDataWidth = 64
);
  logic [InDataWidth-1:0]    data_i;
  logic [InDataWidth/8-1:0]  strb_i;
  logic                      valid_i;
  logic                      ready_o;
  logic [OutDataWidth-1:0]   data_o;
  logic [OutDataWidth/8-1:0] strb_o;
  logic                      valid_o;
  logic                      ready_i;
`ifdef APBDMA_UPSIZER_FLUSH_EN
  logic                      flush_i;
`endif

  modport slave (
`ifdef APBDMA_UPSIZER_FLUSH_EN
    input  flush_i,
`endif
    input  data_i, strb_i, valid_i, ready_i,
    output ready_o, data_o, strb_o, valid_o
  );

  modport master (
`ifdef APBDMA_UPSIZER_FLUSH_EN
    output flush_i,
`endif
    output data_i, strb_i, valid_i, ready_i,
    input  ready_o, data_o, strb_o, valid_o
  );
endinterface

// File: rtl/apbdma_upsizer.sv
// Narrow-to-wide stream packer, little-endian lane order.
// Define APBDMA_UPSIZER_FLUSH_EN to allow emitting partial words.
module apbdma_upsizer
  import apbdma_pkg::*;
#(
  parameter int unsigned InDataWidth  = 32,
  parameter int unsigned OutDataWidth = 64
) (
  input logic               clk_i,
  input logic               rst_ni,
  apbdma_upsizer_if.slave   bus
);

  localparam int unsigned Ratio   = OutDataWidth / InDataWidth;
  localparam int unsigned InStrbW = InDataWidth / 8;
  localparam int unsigned OutStrbW = OutDataWidth / 8;
  localparam int unsigned CntW    = (Ratio > 1) ? $clog2(Ratio) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Ratio - 1);

  if (Ratio < 2 || (Ratio & (Ratio - 1)) != 0
      || (InDataWidth % 8) != 0) begin : g_bad_cfg
    $error("apbdma_upsizer: Ratio must be a power of two >= 2");
  end

  upsizer_state_e        state_q, state_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [OutDataWidth-1:0] data_q, data_d;
  logic [OutStrbW-1:0]   strb_q, strb_d;

  logic ready;
  logic beat;
  logic flush;

  assign ready = (state_q == Fill) || bus.ready_i;
  assign beat  = bus.valid_i && ready;

`ifdef APBDMA_UPSIZER_FLUSH_EN
  assign flush = bus.flush_i;
`else
  assign flush = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    data_d  = data_q;
    strb_d  = strb_q;
    unique case (state_q)
      Fill: begin
        if (beat) begin
          data_d[int'(count_q)*InDataWidth +: InDataWidth] = bus.data_i;
          strb_d[int'(count_q)*InStrbW +: InStrbW] = bus.strb_i;
        end
        if (beat && count_q == LastCnt) begin
          count_d = '0;
          state_d = Full;
        end else if (flush && (beat || count_q != '0)) begin
          count_d = '0;
          state_d = Full;
        end else if (beat) begin
          count_d = count_q + 1'b1;
        end
      end
      Full: begin
        if (bus.ready_i) begin
          // Word leaves; an overlapping beat starts the next word in lane 0.
          strb_d  = '0;
          count_d = '0;
          state_d = Fill;
          if (beat) begin
            data_d[InDataWidth-1:0] = bus.data_i;
            strb_d[InStrbW-1:0]     = bus.strb_i;
            count_d = CntW'(1);
          end
        end
      end
      default: state_d = Fill;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= Fill;
      count_q <= '0;
      data_q  <= '0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
    end
  end

  assign bus.ready_o = ready;
  assign bus.valid_o = (state_q == Full);
  assign bus.data_o  = data_q;
  assign bus.strb_o  = strb_q;

endmodule

// File: tb/tb_apbdma_upsizer.sv
// Directed bench for apbdma_upsizer (32 -> 64 bits).
// Vector table plus hand sequences for reset and flush.
module tb_apbdma_upsizer;

  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apbdma_upsizer_if #(.InDataWidth(32), .OutDataWidth(64)) bus ();

  apbdma_upsizer #(.InDataWidth(32), .OutDataWidth(64)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic        valid;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        rdy;
    logic        e_ready;
    logic        e_valid;
    logic [63:0] e_data;
    logic [7:0]  e_strb;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d,
                       input logic [3:0] s, input logic r);
    bus.valid_i = v;
    bus.data_i  = d;
    bus.strb_i  = s;
    bus.ready_i = r;
  endtask

  initial begin
    // {valid, data, strb, ready_i, exp ready_o, exp valid_o, exp data, exp strb}
    vecs[0]  = '{1, 32'h11111111, 4'hF, 1, 1, 0, 64'h0, 8'h00};
    vecs[1]  = '{1, 32'h22222222, 4'hF, 1, 1, 0, 64'h0, 8'h00};
    vecs[2]  = '{1, 32'h33333333, 4'hF, 1, 1, 1, 64'h22222222_11111111, 8'hFF};
    vecs[3]  = '{1, 32'h44444444, 4'hF, 1, 1, 0, 64'h0, 8'h00};
    vecs[4]  = '{1, 32'h55555555, 4'hF, 1, 1, 1, 64'h44444444_33333333, 8'hFF};
    vecs[5]  = '{1, 32'h66666666, 4'hF, 1, 1, 0, 64'h0, 8'h00};
    vecs[6]  = '{0, 32'h0,        4'h0, 1, 1, 1, 64'h66666666_55555555, 8'hFF};
    vecs[7]  = '{1, 32'h77777777, 4'hF, 1, 1, 0, 64'h0, 8'h00};
    vecs[8]  = '{1, 32'h88888888, 4'hF, 1, 1, 0, 64'h0, 8'h00};
    vecs[9]  = '{1, 32'h99999999, 4'hF, 0, 0, 1, 64'h88888888_77777777, 8'hFF};
    vecs[10] = '{1, 32'h99999999, 4'hF, 0, 0, 1, 64'h88888888_77777777, 8'hFF};
    vecs[11] = '{1, 32'h99999999, 4'hF, 1, 1, 1, 64'h88888888_77777777, 8'hFF};
    vecs[12] = '{1, 32'hBBBBBBBB, 4'hF, 1, 1, 0, 64'h0, 8'h00};
    vecs[13] = '{0, 32'h0,        4'h0, 1, 1, 1, 64'hBBBBBBBB_99999999, 8'hFF};
    vecs[14] = '{1, 32'h12345678, 4'h3, 1, 1, 0, 64'h0, 8'h00};
    vecs[15] = '{1, 32'h9ABCDEF0, 4'hC, 1, 1, 0, 64'h0, 8'h00};
    vecs[16] = '{0, 32'h0,        4'h0, 1, 1, 1, 64'h9ABCDEF0_12345678, 8'hC3};
    vecs[17] = '{0, 32'h0,        4'h0, 1, 1, 0, 64'h0, 8'h00};

    rst_n = 1'b0;
    drive(0, '0, '0, 1);
`ifdef APBDMA_UPSIZER_FLUSH_EN
    bus.flush_i = 1'b0;
`endif
    #1;
    chk("rst_valid", 64'(bus.valid_o), 64'h0);
    chk("rst_ready", 64'(bus.ready_o), 64'h1);
    chk("rst_data",  bus.data_o, 64'h0);
    chk("rst_strb",  64'(bus.strb_o), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(vecs[i].valid, vecs[i].data, vecs[i].strb, vecs[i].rdy);
      #1;
      chk($sformatf("v%0d_ready", i), 64'(bus.ready_o), 64'(vecs[i].e_ready));
      chk($sformatf("v%0d_valid", i), 64'(bus.valid_o), 64'(vecs[i].e_valid));
      if (vecs[i].e_valid) begin
        chk($sformatf("v%0d_data", i), bus.data_o, vecs[i].e_data);
        chk($sformatf("v%0d_strb", i), 64'(bus.strb_o), 64'(vecs[i].e_strb));
      end
    end

    // Reset while a partial word is held
    @(negedge clk);
    drive(1, 32'hDEADBEEF, 4'hF, 1);
    @(negedge clk);
    drive(0, '0, '0, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(bus.valid_o), 64'h0);
    chk("midrst_strb",  64'(bus.strb_o), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 32'h01010101, 4'hF, 1);
    @(negedge clk);
    drive(1, 32'h02020202, 4'hF, 1);
    #1;
    chk("postrst_mid_valid", 64'(bus.valid_o), 64'h0);
    @(negedge clk);
    drive(0, '0, '0, 1);
    #1;
    chk("postrst_valid", 64'(bus.valid_o), 64'h1);
    chk("postrst_data",  bus.data_o, 64'h02020202_01010101);
    chk("postrst_strb",  64'(bus.strb_o), 64'hFF);
    @(negedge clk);
    #1;
    chk("postrst_drain", 64'(bus.valid_o), 64'h0);

`ifdef APBDMA_UPSIZER_FLUSH_EN
    @(negedge clk);
    drive(1, 32'hAAAAAAAA, 4'hF, 1);
    bus.flush_i = 1'b1;
    @(negedge clk);
    drive(0, '0, '0, 1);
    bus.flush_i = 1'b0;
    #1;
    chk("flush_valid", 64'(bus.valid_o), 64'h1);
    chk("flush_strb",  64'(bus.strb_o), 64'h0F);
    chk("flush_data",  64'(bus.data_o[31:0]), 64'hAAAAAAAA);
    @(negedge clk);
    bus.flush_i = 1'b1;
    #1;
    chk("flush_drain", 64'(bus.valid_o), 64'h0);
    @(negedge clk);
    bus.flush_i = 1'b0;
    #1;
    chk("flush_empty", 64'(bus.valid_o), 64'h0);
    // Word after a flush must be a full clean word
    drive(1, 32'h0A0A0A0A, 4'hF, 1);
    @(negedge clk);
    drive(1, 32'h0B0B0B0B, 4'hF, 1);
    @(negedge clk);
    drive(0, '0, '0, 1);
    #1;
    chk("after_flush_data", bus.data_o, 64'h0B0B0B0B_0A0A0A0A);
    chk("after_flush_strb", 64'(bus.strb_o), 64'hFF);
`endif

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
